ahb_bram_ctrl: RTL

AHB_BRAM_CTRL -- requirements
Module: ahb_bram_ctrl

---
 rtl/ahb_pkg.sv | 42 ++++
 rtl/ahb_byte_lane_dec.sv | 21 ++
 rtl/ahb_bram_ctrl.sv | 96 +++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB encodings and small helpers for AHB slaves.
package ahb_pkg;

   localparam int unsigned AHB_DATA_W = 32;
   localparam int unsigned AHB_LANES  = AHB_DATA_W / 8;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [2:0] {
      HSIZE_BYTE = 3'b000,
      HSIZE_HALF = 3'b001,
      HSIZE_WORD = 3'b010
   } hsize_e;

   localparam logic HRESP_OKAY = 1'b0;

   // Forwarded write bytes held for one read data phase
   typedef struct packed {
      logic [AHB_DATA_W-1:0] data;
      logic [AHB_LANES-1:0]  mask;
   } fwd_t;

   // Take fwd bytes where mask is set, ram bytes elsewhere (little-endian lanes)
   function automatic logic [AHB_DATA_W-1:0] merge_lanes(
      input logic [AHB_DATA_W-1:0] fwd,
      input logic [AHB_LANES-1:0]  mask,
      input logic [AHB_DATA_W-1:0] ram
   );
      logic [AHB_DATA_W-1:0] r;
      r = ram;
      for (int n = 0; n < int'(AHB_LANES); n++) begin
         if (mask[n]) r[8*n +: 8] = fwd[8*n +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/ahb_byte_lane_dec.sv
// Combinational AHB byte-lane decode: transfer size and address LSBs to a lane mask.
module ahb_byte_lane_dec
   import ahb_pkg::*;
(
   input  logic [2:0] hsize_i,
   input  logic [1:0] addr_lo_i,
   output logic [3:0] lane_mask_o
);

   // Unsupported sizes produce an empty mask so no bytes are written
   always_comb begin
      lane_mask_o = 4'b0000;
      case (hsize_i)
         HSIZE_BYTE: lane_mask_o = 4'b0001 << addr_lo_i;
         HSIZE_HALF: lane_mask_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
         HSIZE_WORD: lane_mask_o = 4'b1111;
         default:    lane_mask_o = 4'b0000;
      endcase
   end

endmodule

// File: rtl/ahb_bram_ctrl.sv
// Zero-wait-state AHB slave front end for a dual-port byte-write block RAM,
// with read-after-write forwarding for the RAM's read-first behaviour.
module ahb_bram_ctrl
   import ahb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 14
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  HSEL,
   input  logic [31:0]           HADDR,
   input  logic [1:0]            HTRANS,
   input  logic                  HWRITE,
   input  logic [2:0]            HSIZE,
   input  logic [31:0]           HWDATA,
   input  logic                  HREADY,
   output logic                  HREADYOUT,
   output logic                  HRESP,
   output logic [31:0]           HRDATA,
   output logic [ADDR_WIDTH-1:0] ram_addra,
   output logic [3:0]            ram_wea,
   output logic [31:0]           ram_dina,
   output logic [ADDR_WIDTH-1:0] ram_addrb,
   input  logic [31:0]           ram_doutb
);

   logic                  accept;
   logic [ADDR_WIDTH-1:0] addr_idx;
   logic [3:0]            lane_mask;
   logic                  fwd_hit;

   logic                  wr_q,   wr_d;
   logic [ADDR_WIDTH-1:0] idx_q,  idx_d;
   logic [3:0]            mask_q, mask_d;
   fwd_t                  fwd_q,  fwd_d;

   // Sequential-burst bit and address bits above the RAM are not decoded
   logic unused_ok;
   assign unused_ok = ^{HTRANS[0], HADDR[31:ADDR_WIDTH+2]};

   assign accept   = HSEL & HREADY & HTRANS[1];
   assign addr_idx = HADDR[ADDR_WIDTH+1:2];

   ahb_byte_lane_dec u_lane_dec (
      .hsize_i     (HSIZE),
      .addr_lo_i   (HADDR[1:0]),
      .lane_mask_o (lane_mask)
   );

   // Data-phase and forwarding next-state
   always_comb begin
      wr_d    = 1'b0;
      idx_d   = idx_q;
      mask_d  = mask_q;
      fwd_d   = fwd_q;
      fwd_hit = accept & ~HWRITE & (ram_wea != 4'b0000) & (idx_q == addr_idx);
      if (accept) begin
         wr_d   = HWRITE;
         idx_d  = addr_idx;
         mask_d = lane_mask;
      end
      fwd_d.mask = fwd_hit ? mask_q : 4'b0000;
      if (fwd_hit) fwd_d.data = HWDATA;
   end

   // Data-phase and forwarding registers; reset aborts a pending write at once
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         wr_q   <= 1'b0;
         idx_q  <= '0;
         mask_q <= 4'b0000;
         fwd_q  <= '0;
      end else begin
         wr_q   <= wr_d;
         idx_q  <= idx_d;
         mask_q <= mask_d;
         fwd_q  <= fwd_d;
      end
   end

   // RAM ports: write in the data phase, read address straight from the bus
   always_comb begin
      ram_wea   = wr_q ? mask_q : 4'b0000;
      ram_addra = idx_q;
      ram_dina  = HWDATA;
      ram_addrb = addr_idx;
   end

   // Bus response: always ready and OKAY, read data merged with forwarded bytes
   always_comb begin
      HREADYOUT = 1'b1;
      HRESP     = HRESP_OKAY;
      HRDATA    = merge_lanes(fwd_q.data, fwd_q.mask, ram_doutb);
   end

endmodule
